// File: rtl/rename_retire_queue_pkg.sv
// Shared widths for the rename file / retire queue pair.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rename_retire_queue_pkg;

   localparam int RENAME_NAME_WIDTH = 1;
   localparam int RENAME_TAG_WIDTH  = 2;
   localparam int DEPTH             = 1 << RENAME_TAG_WIDTH;

   // Number of queue slots addressed by a tag of the given width.
   function automatic int depth_of(input int tag_w);
      return 1 << tag_w;
   endfunction

endpackage

// File: rtl/rename_retire_slots.sv
// Slot storage for the retire queue: name, valid and done per slot.
// Latency: writes/sets/clears visible one cycle later; read port is combinational.
// Backpressure: none here; the top decides which ports fire.
module rename_retire_slots
   import rename_retire_queue_pkg::*;
#(
   parameter int name_width = RENAME_NAME_WIDTH,
   parameter int tag_width  = RENAME_TAG_WIDTH,
   parameter int depth      = depth_of(tag_width)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_e,
   input  logic [tag_width-1:0]  wr_tag,
   input  logic [name_width-1:0] wr_name,
   input  logic                  set_e_1,
   input  logic [tag_width-1:0]  set_tag_1,
   input  logic                  set_e_2,
   input  logic [tag_width-1:0]  set_tag_2,
   input  logic                  clr_e,
   input  logic [tag_width-1:0]  clr_tag,
   input  logic [tag_width-1:0]  rd_tag,
   output logic [name_width-1:0] rd_name,
   output logic                  rd_valid,
   output logic                  rd_done
);

   logic [name_width-1:0] name_q [depth];
   logic [depth-1:0]      valid_q;
   logic [depth-1:0]      done_q;

   // Name storage is only written on enqueue and is never reset.
   always_ff @(posedge clk) begin
      if (wr_e) begin
         name_q[wr_tag] <= wr_name;
      end
   end

   // Flag update: done sets only land on slots already valid; clear and write override them.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         done_q  <= '0;
      end else begin
         if (set_e_1 && valid_q[set_tag_1]) begin
            done_q[set_tag_1] <= 1'b1;
         end
         if (set_e_2 && valid_q[set_tag_2]) begin
            done_q[set_tag_2] <= 1'b1;
         end
         if (clr_e) begin
            valid_q[clr_tag] <= 1'b0;
            done_q[clr_tag]  <= 1'b0;
         end
         if (wr_e) begin
            valid_q[wr_tag] <= 1'b1;
            done_q[wr_tag]  <= 1'b0;
         end
      end
   end

   assign rd_name  = name_q[rd_tag];
   assign rd_valid = valid_q[rd_tag];
   assign rd_done  = done_q[rd_tag];

endmodule

// File: rtl/rename_retire_queue.sv
// In-order retire queue: records allocated names, retires completed head entries to the free port.
// Latency: done mark -> RETIRE_READY one cycle; FE combinational from state and RETIRE_E.
// Backpressure: ENQ_READY low when full (no bypass through a retiring slot); retire waits on RETIRE_E.
module rename_retire_queue
   import rename_retire_queue_pkg::*;
#(
   parameter int name_width = RENAME_NAME_WIDTH,
   parameter int tag_width  = RENAME_TAG_WIDTH,
   parameter int depth      = depth_of(tag_width)   // must equal 2**tag_width
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [name_width-1:0] ENQ_NAME,
   input  logic                  ENQ_E,
   output logic                  ENQ_READY,
   output logic [tag_width-1:0]  ENQ_TAG,
   input  logic [tag_width-1:0]  DONE_TAG_1,
   input  logic                  DONE_E_1,
   input  logic [tag_width-1:0]  DONE_TAG_2,
   input  logic                  DONE_E_2,
   input  logic                  RETIRE_E,
   output logic                  RETIRE_READY,
   output logic [name_width-1:0] NAME_F,
   output logic                  FE,
   output logic [tag_width:0]    COUNT
);

   localparam logic [tag_width:0]   FULL_COUNT = (tag_width+1)'(depth);
   localparam logic [tag_width-1:0] ONE_TAG    = 1;

   logic [tag_width-1:0]  head;
   logic [tag_width-1:0]  tail;
   logic [tag_width:0]    count;
   logic [name_width-1:0] head_name;
   logic                  head_valid;
   logic                  head_done;
   logic                  enq_fire;
   logic                  ret_fire;

   assign ENQ_READY    = (count != FULL_COUNT);
   assign ENQ_TAG      = tail;
   assign COUNT        = count;
   assign enq_fire     = ENQ_E & ENQ_READY;
   assign RETIRE_READY = head_valid & head_done;
   // Reset cycle must never free a name, even if the head looked retirable.
   assign ret_fire     = RETIRE_E & RETIRE_READY & ~RST;
   assign FE           = ret_fire;
   assign NAME_F       = RETIRE_READY ? head_name : '0;

   rename_retire_slots #(
      .name_width (name_width),
      .tag_width  (tag_width),
      .depth      (depth)
   ) u_slots (
      .clk       (CLK),
      .rst       (RST),
      .wr_e      (enq_fire),
      .wr_tag    (tail),
      .wr_name   (ENQ_NAME),
      .set_e_1   (DONE_E_1),
      .set_tag_1 (DONE_TAG_1),
      .set_e_2   (DONE_E_2),
      .set_tag_2 (DONE_TAG_2),
      .clr_e     (ret_fire),
      .clr_tag   (head),
      .rd_tag    (head),
      .rd_name   (head_name),
      .rd_valid  (head_valid),
      .rd_done   (head_done)
   );

   // Pointer and occupancy tracking; pointers wrap naturally at 2**tag_width.
   always_ff @(posedge CLK) begin
      if (RST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq_fire) begin
            tail <= tail + ONE_TAG;
         end
         if (ret_fire) begin
            head <= head + ONE_TAG;
         end
         case ({enq_fire, ret_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_rename_retire_queue.sv
module tb_rename_retire_queue;

   localparam int NW = 4;
   localparam int TW = 2;
   localparam int DP = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [NW-1:0] ENQ_NAME = '0;
   logic          ENQ_E = 1'b0;
   logic          ENQ_READY;
   logic [TW-1:0] ENQ_TAG;
   logic [TW-1:0] DONE_TAG_1 = '0;
   logic          DONE_E_1 = 1'b0;
   logic [TW-1:0] DONE_TAG_2 = '0;
   logic          DONE_E_2 = 1'b0;
   logic          RETIRE_E = 1'b0;
   logic          RETIRE_READY;
   logic [NW-1:0] NAME_F;
   logic          FE;
   logic [TW:0]   COUNT;

   int checks = 0;
   int errors = 0;
   logic [NW-1:0] sb_q[$];
   logic [TW-1:0] exp_tail = '0;

   rename_retire_queue #(
      .name_width (NW),
      .tag_width  (TW),
      .depth      (DP)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .ENQ_NAME     (ENQ_NAME),
      .ENQ_E        (ENQ_E),
      .ENQ_READY    (ENQ_READY),
      .ENQ_TAG      (ENQ_TAG),
      .DONE_TAG_1   (DONE_TAG_1),
      .DONE_E_1     (DONE_E_1),
      .DONE_TAG_2   (DONE_TAG_2),
      .DONE_E_2     (DONE_E_2),
      .RETIRE_E     (RETIRE_E),
      .RETIRE_READY (RETIRE_READY),
      .NAME_F       (NAME_F),
      .FE           (FE),
      .COUNT        (COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Every free pulse must return the oldest outstanding allocated name.
   always @(negedge CLK) begin
      if (!RST && FE) begin
         if (sb_q.size() == 0) check("fe_unexpected", 32'd1, 32'd0);
         else check("fe_name", 32'(NAME_F), 32'(sb_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic enq(input logic [NW-1:0] n);
      check("enq_tag", 32'(ENQ_TAG), 32'(exp_tail));
      check("enq_ready", 32'(ENQ_READY), 32'd1);
      ENQ_NAME = n;
      ENQ_E = 1'b1;
      sb_q.push_back(n);
      exp_tail++;
      tick();
      ENQ_E = 1'b0;
   endtask

   task automatic done1(input logic [TW-1:0] t);
      DONE_TAG_1 = t;
      DONE_E_1 = 1'b1;
      tick();
      DONE_E_1 = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (COUNT != 0 && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(COUNT == 0), 32'd1);
      check({tag, "_sb"}, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [TW-1:0] t0;
      logic [TW-1:0] t1;
      logic [TW-1:0] last_tag;
      logic          have_last;
      int            sent;

      // Reset and idle
      repeat (2) tick();
      RST = 1'b0;
      #1;
      check("rst_enq_ready", 32'(ENQ_READY), 32'd1);
      check("rst_enq_tag", 32'(ENQ_TAG), 32'd0);
      check("rst_count", 32'(COUNT), 32'd0);
      check("rst_retire_ready", 32'(RETIRE_READY), 32'd0);
      check("rst_fe", 32'(FE), 32'd0);
      check("rst_name_f", 32'(NAME_F), 32'd0);
      RETIRE_E = 1'b1;
      #1;
      check("empty_fe", 32'(FE), 32'd0);
      RETIRE_E = 1'b0;
      tick();

      // In-order retire: younger done entry must wait for the head
      enq(4'd5);
      enq(4'd6);
      enq(4'd7);
      check("count3", 32'(COUNT), 32'd3);
      DONE_TAG_1 = 2'd1;
      DONE_E_1 = 1'b1;
      RETIRE_E = 1'b1;
      #1;
      check("fe_not_head", 32'(FE), 32'd0);
      tick();
      DONE_E_1 = 1'b0;
      check("fe_head_pending", 32'(FE), 32'd0);
      check("rr_head_pending", 32'(RETIRE_READY), 32'd0);
      DONE_TAG_1 = 2'd0;
      DONE_E_1 = 1'b1;
      #1;
      check("fe_no_bypass", 32'(FE), 32'd0);
      tick();
      DONE_E_1 = 1'b0;
      check("fe_first", 32'(FE), 32'd1);
      check("name_first", 32'(NAME_F), 32'd5);
      tick();
      check("fe_second", 32'(FE), 32'd1);
      check("name_second", 32'(NAME_F), 32'd6);
      tick();
      check("fe_stop", 32'(FE), 32'd0);
      check("count1", 32'(COUNT), 32'd1);
      check("name_idle_zero", 32'(NAME_F), 32'd0);
      RETIRE_E = 1'b0;

      // Dual done on tag 2, done on invalid tag 3 ignored
      DONE_TAG_1 = 2'd2;
      DONE_E_1 = 1'b1;
      DONE_TAG_2 = 2'd2;
      DONE_E_2 = 1'b1;
      tick();
      DONE_E_1 = 1'b0;
      DONE_E_2 = 1'b0;
      check("dual_done_rr", 32'(RETIRE_READY), 32'd1);
      check("dual_done_name", 32'(NAME_F), 32'd7);
      done1(2'd3);
      enq(4'd9);
      RETIRE_E = 1'b1;
      #1;
      check("fe_tag2", 32'(FE), 32'd1);
      tick();
      check("tag3_not_done", 32'(RETIRE_READY), 32'd0);
      check("tag3_fe", 32'(FE), 32'd0);
      done1(2'd3);
      check("fe_tag3", 32'(FE), 32'd1);
      tick();
      RETIRE_E = 1'b0;
      check("count_empty", 32'(COUNT), 32'd0);
      check("tail_wrapped", 32'(ENQ_TAG), 32'(exp_tail));

      // Full boundary: no enqueue through a retiring slot
      enq(4'd1);
      enq(4'd2);
      enq(4'd3);
      enq(4'd4);
      check("full_ready", 32'(ENQ_READY), 32'd0);
      check("full_count", 32'(COUNT), 32'd4);
      ENQ_NAME = 4'd15;
      ENQ_E = 1'b1;
      RETIRE_E = 1'b1;
      DONE_TAG_1 = 2'd0;
      DONE_E_1 = 1'b1;
      #1;
      check("full_fe_pending", 32'(FE), 32'd0);
      tick();
      DONE_E_1 = 1'b0;
      check("full_fe", 32'(FE), 32'd1);
      check("full_no_bypass", 32'(ENQ_READY), 32'd0);
      tick();
      ENQ_E = 1'b0;
      RETIRE_E = 1'b0;
      check("full_count3", 32'(COUNT), 32'd3);
      check("full_ready_after", 32'(ENQ_READY), 32'd1);
      check("full_tail_held", 32'(ENQ_TAG), 32'(exp_tail));
      DONE_TAG_1 = 2'd1;
      DONE_E_1 = 1'b1;
      DONE_TAG_2 = 2'd2;
      DONE_E_2 = 1'b1;
      tick();
      DONE_E_2 = 1'b0;
      DONE_TAG_1 = 2'd3;
      tick();
      DONE_E_1 = 1'b0;
      RETIRE_E = 1'b1;
      wait_drain("full_drain", 20);
      RETIRE_E = 1'b0;

      // Sustained enqueue/retire across pointer wrap
      sent = 0;
      have_last = 1'b0;
      last_tag = '0;
      RETIRE_E = 1'b1;
      for (int cyc = 0; cyc < 40 && (sent < 10 || COUNT != 0); cyc++) begin
         DONE_E_1 = have_last;
         DONE_TAG_1 = last_tag;
         have_last = 1'b0;
         if (sent < 10) begin
            check("wrap_enq_tag", 32'(ENQ_TAG), 32'(exp_tail));
            check("wrap_enq_ready", 32'(ENQ_READY), 32'd1);
            ENQ_NAME = NW'(sent * 3 + 1);
            ENQ_E = 1'b1;
            sb_q.push_back(NW'(sent * 3 + 1));
            last_tag = exp_tail;
            exp_tail++;
            have_last = 1'b1;
            sent++;
         end else begin
            ENQ_E = 1'b0;
         end
         tick();
         check("wrap_count_max", 32'(COUNT <= 4), 32'd1);
      end
      ENQ_E = 1'b0;
      DONE_E_1 = 1'b0;
      wait_drain("wrap_drain", 10);
      RETIRE_E = 1'b0;

      // Reset mid-operation discards entries without freeing any
      t0 = exp_tail;
      t1 = t0 + 2'd1;
      enq(4'd10);
      enq(4'd11);
      enq(4'd12);
      DONE_TAG_1 = t0;
      DONE_E_1 = 1'b1;
      DONE_TAG_2 = t1;
      DONE_E_2 = 1'b1;
      tick();
      DONE_E_1 = 1'b0;
      DONE_E_2 = 1'b0;
      check("pre_rst_rr", 32'(RETIRE_READY), 32'd1);
      RST = 1'b1;
      RETIRE_E = 1'b1;
      #1;
      check("fe_in_reset", 32'(FE), 32'd0);
      tick();
      RST = 1'b0;
      sb_q.delete();
      exp_tail = '0;
      #1;
      check("post_rst_count", 32'(COUNT), 32'd0);
      check("post_rst_tag", 32'(ENQ_TAG), 32'd0);
      check("post_rst_rr", 32'(RETIRE_READY), 32'd0);
      check("post_rst_fe", 32'(FE), 32'd0);
      check("post_rst_ready", 32'(ENQ_READY), 32'd1);
      RETIRE_E = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rename_retire_queue.md
Name: rename_retire_queue

Overview:
- In-order retirement queue that sits directly downstream of the forwarding rename register file.
- Records each physical name at allocation, in program order, and marks entries complete when their result is written.
- Retires completed entries strictly in order, driving the rename file's free port (NAME_F/FE) so the superseded name is returned to the free list.
- One entry per allocation; the returned tag travels with the instruction down the pipeline.

Parameters:
- name_width, 1, width of a physical register name
- tag_width, 2, width of a queue slot index
- depth, 4, number of slots; must equal 2**tag_width

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous, active-high reset
- ENQ_NAME  input  name_width  physical name just allocated by the rename file
- ENQ_E  input  1  enqueue request; acted on only when ENQ_READY=1
- ENQ_READY  output  1  queue not full
- ENQ_TAG  output  tag_width  slot the next enqueue will occupy (tail pointer)
- DONE_TAG_1  input  tag_width  slot whose result was written (write port 1)
- DONE_E_1  input  1  mark DONE_TAG_1 complete
- DONE_TAG_2  input  tag_width  slot whose result was written (write port 2)
- DONE_E_2  input  1  mark DONE_TAG_2 complete
- RETIRE_E  input  1  commit permission from the pipeline
- RETIRE_READY  output  1  head entry valid and complete
- NAME_F  output  name_width  name of the head entry; forced to 0 when RETIRE_READY=0
- FE  output  1  RETIRE_E & RETIRE_READY; feeds the rename file free enable
- COUNT  output  tag_width+1  current occupancy

Behaviour:
- State:
  - name[depth] array
  - valid[depth] bit vector
  - done[depth] bit vector
  - head and tail pointers, tag_width bits each, wrap modulo depth
  - count register, tag_width+1 bits
- Reset (RST=1 at posedge): valid=0, done=0, head=0, tail=0, count=0. The name array is not reset.
- Outputs after reset: ENQ_READY=1, ENQ_TAG=0, RETIRE_READY=0, FE=0, NAME_F=0, COUNT=0.
- Reset asserted mid-operation discards all entries; no FE is produced during the reset cycle.
- Combinational outputs:
  - ENQ_READY = (count != depth)
  - RETIRE_READY = valid[head] & done[head]
  - FE is combinational from registered state and RETIRE_E; there is no path from ENQ_* or DONE_* to FE.
- Enqueue (ENQ_E & ENQ_READY):
  - name[tail] <= ENQ_NAME, valid[tail] <= 1, done[tail] <= 0, tail <= tail+1 (wraps depth-1 -> 0).
  - ENQ_E while full is ignored; no state changes.
- Done marking:
  - For each port k, if DONE_E_k and valid[DONE_TAG_k], set done[DONE_TAG_k] <= 1.
  - A done targeting an invalid slot is ignored.
  - Both ports targeting the same slot is legal: a single set.
  - A done targeting tail in the same cycle tail is enqueued is ignored, because the slot is not yet valid.
- Retire (FE=1):
  - valid[head] <= 0, done[head] <= 0, head <= head+1 (wraps).
  - Latency from done marking to RETIRE_READY is 1 cycle; there is no same-cycle bypass of done to retire.
- count update:
  - +1 on enqueue only
  - -1 on retire only
  - unchanged when both fire or neither fires
- Full boundary: when count == depth, ENQ_READY=0 even if FE=1 in that cycle. There is no enqueue bypass through a retiring slot.
- Empty boundary: when count == 0, RETIRE_READY=0 regardless of RETIRE_E.
- Simultaneous enqueue, retire and two dones in one cycle are all legal and independent. Enqueue and retire never touch the same slot, except the full case, which is excluded above.
- Order guarantee: FE pulses occur in enqueue order, and only for entries that were marked done.

Decomposition:
- Shared include:
  - RENAME_NAME_WIDTH and RENAME_TAG_WIDTH defaults, shared with the rename file instantiation
  - helper constant DEPTH = 1 << TAG_WIDTH
- One natural sub-module: rename_retire_slots, holding the name/valid/done arrays with one write port, two done-set ports, one clear port and one read port.
- Pointer and count logic stay in the top module.

Test Plan:
- Reset, then idle -> ENQ_READY=1, COUNT=0, RETIRE_READY=0, FE=0, NAME_F=0.
- Enqueue names 5,6,7 (tags 0,1,2); mark tag 1 done; RETIRE_E=1 -> FE stays 0 (head tag 0 not done). Mark tag 0 done -> next cycle FE=1 with NAME_F=5, then FE=1 with NAME_F=6, then FE=0; COUNT=1.
- With depth=4: enqueue 4 entries -> ENQ_READY=0, COUNT=4. Mark head done and assert ENQ_E and RETIRE_E in the same cycle -> the retire occurs, the enqueue is ignored, COUNT=3, ENQ_READY=1 next cycle.
- Wrap-around: sustained enqueue and retire over 10 entries -> tail and head wrap 3->0, FE names match enqueue order exactly, COUNT never exceeds 4.
- DONE_E_1 and DONE_E_2 both on tag 2, plus a DONE_E_1 on an invalid tag 3 -> tag 2 done, tag 3 unaffected (a later enqueue into tag 3 starts with done=0).
- Assert RST with 3 entries, 2 of them done, and RETIRE_E=1 -> no FE during the reset cycle; afterwards COUNT=0, ENQ_TAG=0, RETIRE_READY=0.
